// File: rtl/y86_fetch_sequencer_if.sv
// Instruction-memory bus, PC redirect and decode-side
// instruction handshake of the Y86-64 fetch sequencer.
interface y86_fetch_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_rdata;
  logic              pc_load;
  logic [63:0]       pc_new;
  logic              ins_valid;
  logic              ins_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic [63:0]       valP;
  logic [2:0]        stat;
  logic [63:0]       pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  pc_load, pc_new,
    output ins_valid,
    input  ins_ready,
    output icode, ifun, rA, rB,
    output valC, valP, stat, pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output pc_load, pc_new,
    input  ins_valid,
    output ins_ready,
    input  icode, ifun, rA, rB,
    input  valC, valP, stat, pc
  );
endinterface

// File: rtl/y86_fetch_sequencer.sv
// Byte-serial Y86-64 fetch: walks instruction memory one byte
// at a time and presents a decoded instruction to decode.
module y86_fetch_sequencer #(
  parameter int          ADDR_W    = 10,
  parameter int          IMEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input logic clk,
  input logic rst_n,
  y86_fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    F_OP, F_REG, F_C, OUT, STOP, DRAIN
  } state_t;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [63:0] MEM_END = 64'(IMEM_SIZE);

  function automatic logic [3:0] len_of(
    input logic [3:0] ic
  );
    logic [3:0] n;
    n = 4'd1;
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: n = 4'd2;
      4'h7, 4'h8:             n = 4'd9;
      4'h3, 4'h4, 4'h5:       n = 4'd10;
      default:                n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic legal(
    input logic [3:0] ic,
    input logic [3:0] fn
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (ic > 4'hB):              ok = 1'b0;
      (ic == 4'h2 || ic == 4'h7): ok = (fn <= 4'd6);
      (ic == 4'h6):             ok = (fn <= 4'd3);
      default:                  ok = (fn == 4'd0);
    endcase
    return ok;
  endfunction

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic [63:0]       valc_q, valc_d;
  logic [63:0]       valp_q, valp_d;
  logic [2:0]        stat_q, stat_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] drain_q, drain_d;
  logic              live_q;

  logic        req;
  logic        hit;
  logic [63:0] addr;
  logic [63:0] cbase;
  logic [3:0]  op_ic;
  logic [3:0]  op_fn;
  logic [3:0]  op_len;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;
    k_d     = k_q;
    drain_d = drain_q;
    req     = 1'b0;
    addr    = pc_q;
    op_ic   = bus.imem_rdata[7:4];
    op_fn   = bus.imem_rdata[3:0];
    op_len  = len_of(op_ic);
    cbase   = (icode_q == 4'h7 || icode_q == 4'h8)
            ? 64'd1 : 64'd2;

    case (state_q)
      F_OP: begin
        if (pc_q >= MEM_END) begin
          icode_d = 4'h0;
          ifun_d  = 4'h0;
          ra_d    = 4'hF;
          rb_d    = 4'hF;
          valc_d  = 64'd0;
          valp_d  = pc_q;
          stat_d  = S_ADR;
          state_d = OUT;
        end else begin
          req = live_q;
        end
      end
      F_REG: begin
        req  = 1'b1;
        addr = pc_q + 64'd1;
      end
      F_C: begin
        req  = 1'b1;
        addr = pc_q + cbase + 64'(k_q);
      end
      DRAIN: begin
        req  = 1'b1;
        addr = 64'(drain_q);
      end
      OUT: begin
        if (bus.ins_ready) begin
          pc_d    = valp_q;
          state_d = (stat_q == S_AOK) ? F_OP : STOP;
        end
      end
      default: ;
    endcase

    hit = req && bus.imem_ack;

    if (hit) begin
      case (state_q)
        F_OP: begin
          icode_d = op_ic;
          ifun_d  = op_fn;
          ra_d    = 4'hF;
          rb_d    = 4'hF;
          valc_d  = 64'd0;
          valp_d  = pc_q + 64'(op_len);
          stat_d  = S_AOK;
          k_d     = 3'd0;
          if (!legal(op_ic, op_fn)) begin
            stat_d  = S_INS;
            state_d = OUT;
          end else if (op_len == 4'd1) begin
            if (op_ic == 4'h0) stat_d = S_HLT;
            state_d = OUT;
          end else if (pc_q + 64'(op_len) - 64'd1
                       >= MEM_END) begin
            stat_d  = S_ADR;
            state_d = OUT;
          end else if (op_ic == 4'h7 || op_ic == 4'h8) begin
            state_d = F_C;
          end else begin
            state_d = F_REG;
          end
        end
        F_REG: begin
          ra_d = bus.imem_rdata[7:4];
          rb_d = bus.imem_rdata[3:0];
          if (icode_q inside {4'h3, 4'h4, 4'h5})
            state_d = F_C;
          else
            state_d = OUT;
        end
        F_C: begin
          valc_d[{k_q, 3'b000} +: 8] = bus.imem_rdata;
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = OUT;
        end
        DRAIN: state_d = F_OP;
        default: ;
      endcase
    end

    // A redirect must not orphan a live bus request: drain it first
    if (bus.pc_load) begin
      pc_d = bus.pc_new;
      if (req && !bus.imem_ack) begin
        state_d = DRAIN;
        drain_d = addr[ADDR_W-1:0];
      end else begin
        state_d = F_OP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_OP;
      pc_q    <= RESET_PC;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= S_AOK;
      k_q     <= 3'd0;
      drain_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      live_q  <= 1'b1;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr[ADDR_W-1:0];
  assign bus.ins_valid = (state_q == OUT);
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.rA        = ra_q;
  assign bus.rB        = rb_q;
  assign bus.valC      = valc_q;
  assign bus.valP      = valp_q;
  assign bus.stat      = stat_q;
  assign bus.pc        = pc_q;

endmodule
